// File: rtl/incubator_plant.sv
// Thermal plant model for an incubator: heater, cooler and ambient drift
// acting on a clamped signed temperature, stepped on a divided tick.
module incubator_plant #(
    parameter int TICK_DIV  = 4,
    parameter int DRIFT_DIV = 4,
    parameter int T_INIT    = 25,
    parameter int T_AMB     = 25,
    parameter int T_MIN     = -40,
    parameter int T_MAX     = 100,
    parameter int HEAT_STEP = 1
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       Heater,
    input  logic       Cooler,
    input  logic [3:0] CRS,
    input  logic       ambient_en,
    output logic [7:0] T,
    output logic [1:0] mode,
    output logic       fault
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;

    localparam logic signed [9:0] LO   = 10'(T_MIN);
    localparam logic signed [9:0] HI   = 10'(T_MAX);
    localparam logic signed [9:0] AMB  = 10'(T_AMB);
    localparam logic signed [9:0] STEP = 10'(HEAT_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10,
        FLT  = 2'b11
    } mode_t;

    mode_t             st, st_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [7:0]        t_q, t_n;
    logic              flt_q, flt_n;
    logic              tick, wrap;
    logic signed [9:0] t_ext, sum;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            st    <= IDLE;
            tcnt  <= '0;
            dcnt  <= '0;
            t_q   <= 8'(T_INIT);
            flt_q <= 1'b0;
        end else begin
            st    <= st_n;
            tcnt  <= tcnt_n;
            dcnt  <= dcnt_n;
            t_q   <= t_n;
            flt_q <= flt_n;
        end
    end

    always_comb begin
        st_n   = IDLE;
        dcnt_n = dcnt;
        wrap   = 1'b0;
        sum    = '0;
        t_n    = t_q;
        t_ext  = {{2{t_q[7]}}, t_q};
        tick   = (tcnt == TW'(TICK_DIV - 1));
        tcnt_n = tick ? '0 : tcnt + TW'(1);

        case ({Heater, Cooler})
            2'b10:   st_n = HEAT;
            2'b01:   st_n = COOL;
            2'b11:   st_n = FLT;
            default: st_n = IDLE;
        endcase
        flt_n = (st_n == FLT);

        // A mode change restarts the drift interval from zero
        if (st_n != st) begin
            dcnt_n = '0;
        end else if (st_n == IDLE && tick) begin
            if (dcnt == DW'(DRIFT_DIV - 1)) begin
                dcnt_n = '0;
                wrap   = 1'b1;
            end else begin
                dcnt_n = dcnt + DW'(1);
            end
        end

        sum = t_ext;
        if (tick) begin
            case (st_n)
                HEAT: sum = t_ext + STEP;
                COOL: sum = t_ext - $signed({7'b0, CRS[3:1]});
                IDLE: begin
                    if (wrap && ambient_en) begin
                        if (t_ext < AMB)
                            sum = t_ext + 10'sd1;
                        else if (t_ext > AMB)
                            sum = t_ext - 10'sd1;
                    end
                end
                default: sum = t_ext;
            endcase
        end

        // Clamp in the wide domain so no result ever wraps in 8 bits
        if (sum < LO)
            t_n = LO[7:0];
        else if (sum > HI)
            t_n = HI[7:0];
        else
            t_n = sum[7:0];
    end

    assign T     = t_q;
    assign mode  = st;
    assign fault = flt_q;

endmodule

// File: tb/tb_incubator_plant.sv
// Directed bench for incubator_plant: table of multi-cycle steps
// plus hand-written reset, clamp, fault, tick-phase and sweep sequences.
module tb_incubator_plant;

    logic       clk;
    logic       rstN;
    logic       Heater;
    logic       Cooler;
    logic [3:0] CRS;
    logic       ambient_en;
    logic [7:0] T;
    logic [1:0] mode;
    logic       fault;

    int n_chk;
    int n_fail;

    incubator_plant dut (
        .clk        (clk),
        .rstN       (rstN),
        .Heater     (Heater),
        .Cooler     (Cooler),
        .CRS        (CRS),
        .ambient_en (ambient_en),
        .T          (T),
        .mode       (mode),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              h;
        logic              c;
        logic [3:0]        crs;
        logic              amb;
        int                ncyc;
        logic signed [7:0] et;
        logic [1:0]        em;
        logic              ef;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(bit h, bit c, int crs, bit amb,
                                int n, int et, int em, bit ef);
        vec_t v;
        v.h    = h;
        v.c    = c;
        v.crs  = 4'(crs);
        v.amb  = amb;
        v.ncyc = n;
        v.et   = 8'(et);
        v.em   = 2'(em);
        v.ef   = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int tval();
        return int'($signed(T));
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit h, input bit c, input int crs,
                         input bit amb);
        Heater     = h;
        Cooler     = c;
        CRS        = 4'(crs);
        ambient_en = amb;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        drive(0, 0, 0, 0);
        step(2);
        chk("rst_T", tval(), 25);
        chk("rst_mode", int'(mode), 0);
        chk("rst_fault", int'(fault), 0);
        rstN = 1'b1;
    endtask

    initial begin
        int exp_t;
        n_chk  = 0;
        n_fail = 0;
        rstN   = 1'b0;
        drive(0, 0, 0, 0);

        vt[0]  = mk(1, 0, 0, 0, 40, 35, 1, 0);
        vt[1]  = mk(0, 1, 8, 0, 20, 15, 2, 0);
        vt[2]  = mk(0, 1, 1, 0, 8, 15, 2, 0);
        vt[3]  = mk(0, 1, 0, 0, 4, 15, 2, 0);
        vt[4]  = mk(1, 1, 0, 0, 8, 15, 3, 1);
        vt[5]  = mk(1, 0, 0, 0, 20, 20, 1, 0);
        vt[6]  = mk(0, 0, 0, 1, 16, 21, 0, 0);
        vt[7]  = mk(0, 0, 0, 1, 32, 23, 0, 0);
        vt[8]  = mk(0, 0, 0, 0, 16, 23, 0, 0);
        vt[9]  = mk(0, 0, 0, 1, 48, 25, 0, 0);
        vt[10] = mk(0, 1, 15, 0, 40, -40, 2, 0);
        vt[11] = mk(0, 0, 0, 1, 16, -39, 0, 0);
        vt[12] = mk(1, 0, 0, 0, 40, -29, 1, 0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].h, vt[i].c, int'(vt[i].crs), vt[i].amb);
            step(vt[i].ncyc);
            chk($sformatf("vec%0d_T", i), tval(), int'(vt[i].et));
            chk($sformatf("vec%0d_mode", i), int'(mode), int'(vt[i].em));
            chk($sformatf("vec%0d_fault", i), int'(fault), int'(vt[i].ef));
        end

        // First tick lands on the fourth edge after reset release
        do_reset();
        drive(1, 0, 0, 0);
        step(3);
        chk("first_tick_pre", tval(), 25);
        step(1);
        chk("first_tick", tval(), 26);

        // Asynchronous reset in the middle of a cycle
        step(7);
        #2;
        rstN = 1'b0;
        #1;
        chk("async_T", tval(), 25);
        chk("async_mode", int'(mode), 0);
        step(1);
        rstN = 1'b1;

        // Upper clamp
        do_reset();
        drive(1, 0, 0, 0);
        step(292);
        chk("heat_98", tval(), 98);
        step(20);
        chk("clamp_hi", tval(), 100);
        chk("clamp_hi_mode", int'(mode), 1);

        // Fault hold and release
        do_reset();
        drive(1, 0, 0, 0);
        step(20);
        chk("fault_pre_T", tval(), 30);
        drive(1, 1, 0, 0);
        step(1);
        chk("fault_set", int'(fault), 1);
        chk("fault_mode", int'(mode), 3);
        step(7);
        chk("fault_hold_T", tval(), 30);
        drive(1, 0, 0, 0);
        step(1);
        chk("fault_clr", int'(fault), 0);
        chk("fault_clr_mode", int'(mode), 1);
        step(3);
        chk("fault_resume_T", tval(), 31);

        // Heater dropped just before the tick has no effect
        do_reset();
        drive(1, 0, 0, 0);
        step(3);
        drive(0, 0, 0, 0);
        step(1);
        chk("between_ticks_T", tval(), 25);
        chk("between_ticks_mode", int'(mode), 0);

        // Sweep 25 -> -10 -> 60 -> -10 one degree per tick
        do_reset();
        exp_t = 25;
        drive(0, 1, 2, 0);
        for (int k = 0; k < 35; k++) begin
            step(4);
            exp_t--;
            chk("sweep_dn0", tval(), exp_t);
        end
        drive(1, 0, 0, 0);
        for (int k = 0; k < 70; k++) begin
            step(4);
            exp_t++;
            chk("sweep_up", tval(), exp_t);
        end
        drive(0, 1, 3, 0);
        for (int k = 0; k < 70; k++) begin
            step(4);
            exp_t--;
            chk("sweep_dn", tval(), exp_t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/incubator_plant.md
INCUBATOR_PLANT -- requirements
Module: incubator_plant

Interface
REQ-001 Parameter TICK_DIV, default 4: clock cycles per thermal step, at least 2.
REQ-002 Parameter DRIFT_DIV, default 4: thermal steps per 1-degree ambient drift step, at least 1.
REQ-003 Parameter T_INIT, default 25: signed reset temperature.
REQ-004 Parameter T_AMB, default 25: signed ambient target.
REQ-005 Parameter T_MIN, default -40, and T_MAX, default 100: signed clamp limits.
REQ-006 Parameter HEAT_STEP, default 1: degrees added per thermal step while heating.
REQ-007 clk  in  1  single system clock; all state changes on its rising edge.
REQ-008 rstN  in  1  asynchronous, active-low reset.
REQ-009 Heater  in  1  heater drive from the controller.
REQ-010 Cooler  in  1  cooler drive from the controller.
REQ-011 CRS  in  4  cooler rotation speed, unsigned.
REQ-012 ambient_en  in  1  enables drift toward T_AMB while idle.
REQ-013 T  out  8  modelled temperature, two's-complement signed, registered.
REQ-014 mode  out  2  registered: 00 idle, 01 heat, 10 cool, 11 fault.
REQ-015 fault  out  1  registered; high while Heater and Cooler are both high.

Function
REQ-016 The block SHALL keep a tick counter 0..TICK_DIV-1 that increments every clock and wraps; "tick" SHALL mean the edge at which the counter equals TICK_DIV-1.
REQ-017 mode and fault SHALL update every clock edge from current inputs: {H,C} = 00 -> idle, 10 -> heat, 01 -> cool, 11 -> fault with fault=1; otherwise fault=0.
REQ-018 On a tick with Heater=1 and Cooler=0, T SHALL become T+HEAT_STEP.
REQ-019 On a tick with Cooler=1 and Heater=0, T SHALL become T-(CRS>>1); CRS=0 or 1 SHALL hold T while mode still reads cool.
REQ-020 On a tick with both high, T SHALL hold.
REQ-021 While idle, a drift counter 0..DRIFT_DIV-1 SHALL advance once per tick; on wrap, if ambient_en=1, T SHALL move 1 toward T_AMB and SHALL not move when T equals T_AMB.
REQ-022 Any change of the registered mode SHALL clear the drift counter; drift SHALL not occur while heating, cooling or faulted.
REQ-023 Arithmetic SHALL use at least 10-bit signed intermediates, and the result SHALL be clamped to [T_MIN, T_MAX] before T is written, with no 8-bit wrap-around.
REQ-024 Input changes between ticks SHALL affect T only through the values present at the tick edge.

Reset
REQ-025 While rstN=0, regardless of clk: T=T_INIT, mode=00, fault=0, tick counter=0, drift counter=0.
REQ-026 Asserting rstN mid-operation SHALL restore the REQ-025 values immediately, with no partial update.
REQ-027 After rstN rises, the first tick SHALL occur on the TICK_DIV-th rising edge.

Verification (defaults)
REQ-028 Reset: rstN=0 for 2 cycles -> T=25, mode=00, fault=0; assert rstN=0 asynchronously mid-cycle -> T=25 before the next edge.
REQ-029 Heating: Heater=1 for 40 cycles after reset -> T=35 and mode=01; Heater held from T=98 for 20 cycles -> T=100 and stays there.
REQ-030 Cooling: start at T=25, Cooler=1, CRS=8, 20 cycles -> T=5; CRS=15 from T=-36 -> -40 after 1 tick, then holds; CRS=1 -> T unchanged.
REQ-031 Fault: Heater=Cooler=1 at T=30 -> fault=1 and mode=11 at the next edge, T stays 30; release Cooler -> fault=0 next edge and heating resumes.
REQ-032 Drift: T=30, idle, ambient_en=1 -> T=29 after 16 cycles and 26 after 64 cycles, stopping at 25; with ambient_en=0, T stays 30.
REQ-033 Sweep: drive the sweep -10 -> 60 -> -10 by toggling Heater/Cooler; T SHALL track monotonically with no value outside [T_MIN, T_MAX].
